// File: rtl/stream_demux_pkg.sv
// Shared defaults and select range check for the registered 1xN stream demux.
package stream_demux_pkg;

    localparam int DEMUX_WIDTH_DEF = 8;
    localparam int DEMUX_NCH_DEF   = 8;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
        return sel < n;
    endfunction

endpackage

// File: rtl/stream_demux_1xn_slot.sv
// demux_slot: one-entry valid/data holding register for a single output channel.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_acc
);

    assign can_acc = !valid || rd_ready;

    // A write wins over a drain, so a same-cycle drain and fill keeps valid high.
    // Data is only loaded on a write, so it stays stable during a stall and after a drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            data  <= wr_data;
        end else if (rd_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: routes one valid/ready stream to N_CH registered output channels.
// Optional broadcast input in_bcast is enabled by defining STREAM_DEMUX_BCAST_EN.
module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter  int WIDTH = DEMUX_WIDTH_DEF,
    parameter  int N_CH  = DEMUX_NCH_DEF,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
`ifdef STREAM_DEMUX_BCAST_EN
    input  logic                    in_bcast,
`endif
    output logic [N_CH-1:0]         out_valid,
    input  logic [N_CH-1:0]         out_ready,
    output logic [N_CH*WIDTH-1:0]   out_data,
    output logic                    sel_err
);

    logic [N_CH-1:0]  can_acc;
    logic [N_CH-1:0]  wr_en;
    logic [WIDTH-1:0] slot_data [N_CH];
    logic             sel_ok;
    logic             bcast;
    logic             accept;

`ifdef STREAM_DEMUX_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    assign sel_ok = sel_in_range(32'(in_sel), N_CH);
    assign accept = in_valid && in_ready;

    // Out-of-range beats are always sunk, so a bad select can never stall the producer.
    always_comb begin
        in_ready = 1'b1;
        if (bcast) begin
            in_ready = &can_acc;
        end else if (sel_ok) begin
            in_ready = can_acc[in_sel];
        end
    end

    always_comb begin
        wr_en = '0;
        if (accept) begin
            if (bcast) begin
                wr_en = '1;
            end else if (sel_ok) begin
                wr_en[in_sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= accept && !bcast && !sel_ok;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[k]),
            .wr_data  (in_data),
            .rd_ready (out_ready[k]),
            .valid    (out_valid[k]),
            .data     (slot_data[k]),
            .can_acc  (can_acc[k])
        );
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            out_data[k*WIDTH +: WIDTH] = slot_data[k];
        end
    end

endmodule
